mvm_tile_accum: RTL and testbench

//  Downstream of the approximate 2-input MAC array. Accumulates H lanes of partial
//  dot products over TILES successive X-chunks, adds a per-lane bias, saturates to

---
 rtl/mvm_tile_accum_pkg.sv | 16 +
 rtl/mvm_tile_accum_sat_narrow.sv | 22 ++
 rtl/mvm_tile_accum.sv | 142 ++++++++++++++
 tb/tb_mvm_tile_accum.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_tile_accum_pkg.sv
// Shared definitions for the tile accumulator: Q4.4 constants and FSM state codes.
// The HARD_SIGMOID_EN build option uses HSIG_HALF / HSIG_ONE from here.
package mvm_tile_accum_pkg;

    localparam int FRAC_BITS = 4;
    localparam int HSIG_HALF = 8;   // 0.5 in Q4.4
    localparam int HSIG_ONE  = 16;  // 1.0 in Q4.4

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/mvm_tile_accum_sat_narrow.sv
// Signed saturating narrowing from IN_W to OUT_W bits (clamps to the OUT_W signed range).
module mvm_tile_accum_sat_narrow #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  acc_i,
    output logic [OUT_W-1:0] sat_o
);

    localparam logic [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        sat_o = acc_i[OUT_W-1:0];
        if ($signed(acc_i) > $signed(MAX_V)) begin
            sat_o = MAX_V[OUT_W-1:0];
        end else if ($signed(acc_i) < $signed(MIN_V)) begin
            sat_o = MIN_V[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/mvm_tile_accum.sv
// Accumulates TILES partial-sum beats per lane plus a bias, saturates to DATA_WIDTH and
// presents the result on a valid/ready output. Define HARD_SIGMOID_EN to apply a hard sigmoid.
module mvm_tile_accum
    import mvm_tile_accum_pkg::*;
#(
    parameter int H          = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TILES      = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [H*DATA_WIDTH-1:0] in_data,
    input  logic [H*DATA_WIDTH-1:0] bias_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [H*DATA_WIDTH-1:0] out_data,
    output logic [1:0]              dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid and data stable until that edge, ready never depends on valid.

    localparam int DW    = DATA_WIDTH;
    localparam int CNT_W = (TILES < 2) ? 1 : $clog2(TILES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILES - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         tile_cnt_q, tile_cnt_d;
    logic [ACC_WIDTH-1:0]     acc_q [H];
    logic [ACC_WIDTH-1:0]     acc_d [H];
    logic [H*DW-1:0]          out_q, out_d;
    logic [H*DW-1:0]          result_w;
    logic [ACC_WIDTH-1:0]     beat_ext [H];
    logic [ACC_WIDTH-1:0]     bias_ext [H];

    // Lane 0 sits at the MSB end of every packed bus.
    for (genvar m = 0; m < H; m++) begin : g_lane
        logic [DW-1:0] beat_w, bias_w, sat_w, act_w;

        assign beat_w      = in_data[(H-1-m)*DW +: DW];
        assign bias_w      = bias_in[(H-1-m)*DW +: DW];
        assign beat_ext[m] = {{(ACC_WIDTH-DW){beat_w[DW-1]}}, beat_w};
        assign bias_ext[m] = {{(ACC_WIDTH-DW){bias_w[DW-1]}}, bias_w};

        mvm_tile_accum_sat_narrow #(
            .IN_W  (ACC_WIDTH),
            .OUT_W (DW)
        ) u_sat (
            .acc_i (acc_q[m]),
            .sat_o (sat_w)
        );

`ifdef HARD_SIGMOID_EN
        logic [DW-1:0] shr_w;
        logic [DW+1:0] hs_w;
        assign shr_w = DW'($signed(sat_w) >>> 2);
        assign hs_w  = {{2{shr_w[DW-1]}}, shr_w} + (DW+2)'(HSIG_HALF);
        always_comb begin
            act_w = hs_w[DW-1:0];
            if ($signed(hs_w) < 0) begin
                act_w = '0;
            end else if ($signed(hs_w) > $signed((DW+2)'(HSIG_ONE))) begin
                act_w = DW'(HSIG_ONE);
            end
        end
`else
        assign act_w = sat_w;
`endif

        assign result_w[(H-1-m)*DW +: DW] = act_w;
    end

    always_comb begin
        state_d    = state_q;
        tile_cnt_d = tile_cnt_q;
        acc_d      = acc_q;
        out_d      = out_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int m = 0; m < H; m++) begin
                        acc_d[m] = beat_ext[m] + bias_ext[m];
                    end
                    tile_cnt_d = CNT_W'(1);
                    state_d    = (TILES == 1) ? ST_SAT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int m = 0; m < H; m++) begin
                        acc_d[m] = acc_q[m] + beat_ext[m];
                    end
                    tile_cnt_d = tile_cnt_q + CNT_W'(1);
                    if (tile_cnt_q == LAST_CNT) begin
                        state_d = ST_SAT;
                    end
                end
            end
            ST_SAT: begin
                out_d   = result_w;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    tile_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tile_cnt_q <= '0;
            out_q      <= '0;
            for (int m = 0; m < H; m++) begin
                acc_q[m] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tile_cnt_q <= tile_cnt_d;
            out_q      <= out_d;
            for (int m = 0; m < H; m++) begin
                acc_q[m] <= acc_d[m];
            end
        end
    end

    assign out_data    = out_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mvm_tile_accum.sv
// Self-checking bench for mvm_tile_accum (H=2, DATA_WIDTH=8, TILES=4); honours HARD_SIGMOID_EN.
module tb_mvm_tile_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] bias_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] frame_beats[4];
    logic [15:0] held;

    mvm_tile_accum #(
        .H          (2),
        .DATA_WIDTH (8),
        .TILES      (4),
        .ACC_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .bias_in     (bias_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .dbg_state_o (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: bias + sum of beats in plain integers, clamp, optional hard sigmoid.
    function automatic logic [7:0] lane_ref(input int sum);
        int s;
        logic [31:0] r;
        s = (sum > 127) ? 127 : ((sum < -128) ? -128 : sum);
`ifdef HARD_SIGMOID_EN
        s = (s >>> 2) + 8;
        s = (s < 0) ? 0 : ((s > 16) ? 16 : s);
`endif
        r = s;
        return r[7:0];
    endfunction

    function automatic logic [15:0] frame_ref(input logic [15:0] bias);
        int s0, s1;
        s0 = $signed(bias[15:8]);
        s1 = $signed(bias[7:0]);
        for (int i = 0; i < 4; i++) begin
            s0 += $signed(frame_beats[i][15:8]);
            s1 += $signed(frame_beats[i][7:0]);
        end
        return {lane_ref(s0), lane_ref(s1)};
    endfunction

    task automatic send_beat(input logic [15:0] data, input logic [15:0] bias);
        int budget;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        bias_in  = bias;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Bias on beats 2..4 is random junk that the design must ignore.
    task automatic send_frame(input logic [15:0] bias);
        exp_q.push_back(frame_ref(bias));
        for (int i = 0; i < 4; i++) begin
            send_beat(frame_beats[i], (i == 0) ? bias : 16'($urandom));
        end
    endtask

    task automatic fill_frame(input logic [15:0] word);
        for (int i = 0; i < 4; i++) frame_beats[i] = word;
    endtask

    task automatic wait_valid(input string tag);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic recv(input string tag, input int stall);
        logic [15:0] exp;
        wait_valid(tag);
        held = out_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_data"}, 32'(out_data), 32'(held));
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        out_ready = 1'b1;
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        bias_in   = '0;
        out_ready = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame and output latency after the last beat.
        fill_frame(16'h10F0);
        send_frame(16'h0000);
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        check("lat_edge1_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("lat_edge2_valid", 32'(out_valid), 32'd1);
        recv("basic", 0);

        // Saturation at both extremes.
        fill_frame(16'h7F80);
        send_frame(16'h0000);
        recv("sat", 1);

        // Bias sampled with the first beat.
        fill_frame(16'h0400);
        send_frame(16'h08F8);
        recv("bias", 0);

        // Backpressure: held output, no beats consumed while stalled.
        fill_frame(16'h10F0);
        send_frame(16'h0000);
        wait_valid("bp_pre");
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_data", 32'(out_data), 32'(held));
        end
        in_valid = 1'b0;
        recv("bp", 0);
        fill_frame(16'h0101);
        send_frame(16'h0000);
        recv("bp_after", 0);

        // Reset mid-frame discards the partial sum.
        fill_frame(16'h10F0);
        send_beat(16'h10F0, 16'h0000);
        send_beat(16'h10F0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(16'h0000);
        recv("post_rst", 0);

        // Reset while the result is waiting in OUT.
        fill_frame(16'h2233);
        send_frame(16'h0000);
        wait_valid("outrst_pre");
        rst = 1'b1;
        #2;
        check("outrst_valid", 32'(out_valid), 32'd0);
        check("outrst_data", 32'(out_data), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Zero sum (0x08 per lane under the hard sigmoid).
        fill_frame(16'h0000);
        send_frame(16'h0000);
        recv("zero", 0);

        // Randomised frames with random consumer stalls.
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < 4; i++) frame_beats[i] = 16'($urandom);
            send_frame(16'($urandom));
            recv("rand", int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
